// File: rtl/stack_mem_responder_pkg.sv
// Shared constants for the stack-machine memory responder: CPU opcodes,
// the store-marker byte and the responder state encoding.
package stack_mem_responder_pkg;

  localparam logic [7:0] OP_NUL       = 8'd27;
  localparam logic [7:0] OP_PSI       = 8'h0D;
  localparam logic [7:0] OP_FIN       = 8'h1A;
  localparam logic [7:0] STORE_MARKER = 8'hFF;

  typedef logic [1:0] resp_state_t;

  localparam resp_state_t ST_LOAD  = 2'd0;
  localparam resp_state_t ST_RUN   = 2'd1;
  localparam resp_state_t ST_ARMED = 2'd2;

  function automatic logic addr_mapped(input logic [7:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/stack_mem_responder_byte_regfile.sv
// DEPTH x 8 flop memory with one synchronous write port, one combinational
// read port, and every byte reset to FILL.
module byte_regfile
  import stack_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter logic [7:0]  FILL  = 8'h1B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= FILL;
      end
    end else if (we && addr_mapped(waddr, DEPTH)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Unmapped addresses read back as the NUL opcode so a runaway CPU idles.
  always_comb begin
    rdata = FILL;
    if (addr_mapped(raddr, DEPTH)) begin
      rdata = mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/stack_mem_responder.sv
// Memory-side responder for the stack-machine CPU: answers combinational
// reads, decodes the marker/data store protocol and runs the program loader.
module stack_mem_responder
  import stack_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter logic [7:0]  FILL  = 8'h1B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_reset,
  input  logic       load_mode,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_full,
  output logic       wr_strobe
);

  localparam int PW = $clog2(DEPTH + 1);

  resp_state_t   state;
  resp_state_t   next_state;
  logic [PW-1:0] load_ptr;
  logic          load_write;
  logic          mem_we;
  logic [7:0]    mem_waddr;
  logic [7:0]    mem_wdata;

  assign load_full  = (load_ptr == PW'(DEPTH));
  assign load_write = (state == ST_LOAD) && load_valid && !load_full;

  // Address 0 is excluded from arming because FIN parks the bus at 0 with 0xFF.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:  next_state = load_mode ? ST_LOAD : ST_RUN;
      ST_RUN: begin
        if (load_mode) begin
          next_state = ST_LOAD;
        end else if (cpu_wdata == STORE_MARKER && cpu_addr != 8'd0) begin
          next_state = ST_ARMED;
        end
      end
      ST_ARMED: next_state = load_mode ? ST_LOAD : ST_RUN;
      default:  next_state = ST_LOAD;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = 8'd0;
    mem_wdata = 8'd0;
    wr_strobe = 1'b0;
    if (load_write) begin
      mem_we    = 1'b1;
      mem_waddr = 8'(load_ptr);
      mem_wdata = load_data;
    end else if (state == ST_ARMED && !load_mode && addr_mapped(cpu_addr, DEPTH)) begin
      mem_we    = 1'b1;
      mem_waddr = cpu_addr;
      mem_wdata = cpu_wdata;
      wr_strobe = 1'b1;
    end
  end

  // cpu_reset follows next_state so the core is held for a full cycle per load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_LOAD;
      cpu_reset <= 1'b1;
      load_ptr  <= '0;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state == ST_LOAD);
      if (state != ST_LOAD && next_state == ST_LOAD) begin
        load_ptr <= '0;
      end else if (load_write) begin
        load_ptr <= load_ptr + PW'(1);
      end
    end
  end

  byte_regfile #(
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cpu_addr),
    .rdata (cpu_rdata)
  );

endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed, table-driven bench for stack_mem_responder with hand-written
// sequences for the store, FIN, unmapped, loader-overflow and abort cases.
module tb_stack_mem_responder;

  logic       clock;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       load_mode;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_full;
  logic       wr_strobe;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       lm;
    logic       lv;
    logic [7:0] ld;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       e_crst;
    logic       e_full;
    logic       e_ws;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  stack_mem_responder #(
    .DEPTH (32),
    .FILL  (8'h1B)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_reset  (cpu_reset),
    .load_mode  (load_mode),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_full  (load_full),
    .wr_strobe  (wr_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic lm, input logic lv, input logic [7:0] ld,
                                input logic [7:0] addr, input logic [7:0] wdata);
    load_mode  = lm;
    load_valid = lv;
    load_data  = ld;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
  endtask

  // Outputs are sampled on the falling edge, then the bench steps to just past the rising edge.
  task automatic check_output(input string tag, input logic e_crst, input logic e_full,
                              input logic e_ws, input logic [7:0] e_rdata);
    @(negedge clock);
    check_bit({tag, ".cpu_reset"}, cpu_reset, e_crst);
    check_bit({tag, ".load_full"}, load_full, e_full);
    check_bit({tag, ".wr_strobe"}, wr_strobe, e_ws);
    check_byte({tag, ".cpu_rdata"}, cpu_rdata, e_rdata);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_state", 1'b1, 1'b0, 1'b0, 8'h1B);
    reset = 1'b0;

    //             lm    lv    ld     addr   wdata  crst  full  ws    rdata
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd0,   8'h00, 1'b1, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd31,  8'h00, 1'b0, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b1, 1'b1, 8'h77, 8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b1, 1'b1, 8'h0D, 8'd0,   8'h00, 1'b1, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b1, 1'b1, 8'h05, 8'd0,   8'h00, 1'b1, 1'b0, 1'b0, 8'h0D});
    vecs.push_back('{1'b1, 1'b1, 8'h1A, 8'd1,   8'h00, 1'b1, 1'b0, 1'b0, 8'h05});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd2,   8'h00, 1'b1, 1'b0, 1'b0, 8'h1A});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 8'h0D});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd1,   8'h00, 1'b0, 1'b0, 1'b0, 8'h05});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd3,   8'h00, 1'b0, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd4,   8'hFF, 1'b0, 1'b0, 1'b0, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd10,  8'h3C, 1'b0, 1'b0, 1'b1, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'd10,  8'h00, 1'b0, 1'b0, 1'b0, 8'h3C});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].lm, vecs[i].lv, vecs[i].ld, vecs[i].addr, vecs[i].wdata);
      check_output($sformatf("vec%0d", i), vecs[i].e_crst, vecs[i].e_full,
                   vecs[i].e_ws, vecs[i].e_rdata);
    end

    // FIN idle pattern must never arm a store.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 8'd0, 8'hFF);
      check_output($sformatf("fin%0d", i), 1'b0, 1'b0, 1'b0, 8'h0D);
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd5, 8'h00);
    check_output("fin_after", 1'b0, 1'b0, 1'b0, 8'h1B);

    // Unmapped store of 0xFF must not write or re-arm; then a mapped 0xFF store.
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd40, 8'hFF);
    check_output("unmap_marker", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd40, 8'hFF);
    check_output("unmap_data", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd6, 8'h00);
    check_output("unmap_norearm", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd7, 8'hFF);
    check_output("ff_marker", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd7, 8'hFF);
    check_output("ff_data", 1'b0, 1'b0, 1'b1, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd7, 8'h00);
    check_output("ff_readback", 1'b0, 1'b0, 1'b0, 8'hFF);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd6, 8'h00);
    check_output("addr6_intact", 1'b0, 1'b0, 1'b0, 8'h1B);

    // load_mode during the data cycle drops the pending write.
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd8, 8'hFF);
    check_output("abort_marker", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b1, 1'b0, 8'h00, 8'd8, 8'h55);
    check_output("abort_data", 1'b0, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b1, 1'b0, 8'h00, 8'd8, 8'h00);
    check_output("abort_after", 1'b1, 1'b0, 1'b0, 8'h1B);
    apply_stimulus(1'b1, 1'b0, 8'h00, 8'd7, 8'h00);
    check_output("retained7", 1'b1, 1'b0, 1'b0, 8'hFF);

    // 40 back-to-back load bytes: only the first 32 land.
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 1'b1, 8'h80 + 8'(i), 8'd31, 8'h00);
      check_output($sformatf("load%0d", i), 1'b1, (i >= 32), 1'b0,
                   (i >= 32) ? 8'h9F : 8'h1B);
    end
    apply_stimulus(1'b1, 1'b0, 8'h00, 8'd0, 8'h00);
    check_output("load_mem0", 1'b1, 1'b1, 1'b0, 8'h80);
    apply_stimulus(1'b1, 1'b0, 8'h00, 8'd7, 8'h00);
    check_output("load_mem7", 1'b1, 1'b1, 1'b0, 8'h87);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd32, 8'h00);
    check_output("load_drop", 1'b1, 1'b1, 1'b0, 8'h1B);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd31, 8'h00);
    @(negedge clock);
    check_bit("run_again.cpu_reset", cpu_reset, 1'b0);
    check_byte("run_again.cpu_rdata", cpu_rdata, 8'h9F);
    @(posedge clock);
    #1;

    // reset beats an arming marker and refills memory.
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd3, 8'hFF);
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'd0, 8'h00);
    check_output("rereset", 1'b1, 1'b0, 1'b0, 8'h1B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
